// File: rtl/shifter_pkg.sv
// Shared types and helpers for the serial left shifter.
// Optional rotate support is enabled by SERIAL_LEFT_SHIFTER_ROTATE_EN in the top.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Effective step count plus the over-range flag. The 64-bit field
  // covers any operand width up to 64 bits.
  typedef struct packed {
    logic [63:0] s_eff;
    logic        over;
  } clamp_t;

  // Logical mode saturates the step count at n and flags anything beyond.
  // Rotate mode wraps modulo n (n is a power of two), so it is never over range.
  function automatic clamp_t clamp_shift(input logic [63:0] shift,
                                         input int unsigned n,
                                         input logic        rot);
    clamp_t r;
    r.over = 1'b0;
    if (rot) begin
      r.s_eff = shift & (64'(n) - 64'd1);
    end else if (shift > 64'(n)) begin
      r.s_eff = 64'(n);
      r.over  = 1'b1;
    end else begin
      r.s_eff = shift;
    end
    return r;
  endfunction

endpackage

// File: rtl/left_shift_step.sv
// One-bit left shift / rotate stage used once per cycle by the shifter FSM.
module left_shift_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] y_in,
  input  logic         rotate,
  output logic [N-1:0] y_out,
  output logic         carry_out
);

  // The bit leaving the MSB is the carry; it re-enters at the LSB when rotating.
  always_comb begin
    carry_out = y_in[N-1];
    y_out     = {y_in[N-2:0], (rotate ? y_in[N-1] : 1'b0)};
  end

endmodule

// File: rtl/serial_left_shifter.sv
// Multi-cycle logical left shifter, one bit per clock, valid/ready on both sides.
// Define SERIAL_LEFT_SHIFTER_ROTATE_EN to add the `rotate` input (rotate mode).
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | stepping the operand left, count holds remaining steps
// DONE  | result presented, out_valid high until out_ready
module serial_left_shifter
  import shifter_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] shift,
`ifdef SERIAL_LEFT_SHIFTER_ROTATE_EN
  input  logic         rotate,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         carry,
  output logic         zero
);

  logic         rot_in;
`ifdef SERIAL_LEFT_SHIFTER_ROTATE_EN
  assign rot_in = rotate;
`else
  assign rot_in = 1'b0;
`endif

  state_t       state_q, state_d;
  logic [N-1:0] y_q, y_d;
  logic         carry_q, carry_d;
  logic [CW-1:0] count_q, count_d;
  logic         over_q, over_d;
  logic         rotate_q, rotate_d;

  logic [N-1:0] step_y;
  logic         step_c;
  clamp_t       clamp;
  logic         accept;

  assign clamp  = clamp_shift(64'(shift), N, rot_in);
  assign accept = in_valid && (state_q == IDLE);

  left_shift_step #(.N(N)) u_step (
    .y_in      (y_q),
    .rotate    (rotate_q),
    .y_out     (step_y),
    .carry_out (step_c)
  );

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      y_q      <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      over_q   <= 1'b0;
      rotate_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      over_q   <= over_d;
      rotate_q <= rotate_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (count_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, step while count is nonzero.
  always_comb begin
    y_d      = y_q;
    carry_d  = carry_q;
    count_d  = count_q;
    over_d   = over_q;
    rotate_d = rotate_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          y_d      = a;
          carry_d  = 1'b0;
          count_d  = CW'(clamp.s_eff);
          over_d   = clamp.over;
          rotate_d = rot_in;
        end
      end
      SHIFT: begin
        if (count_q != '0) begin
          y_d     = step_y;
          carry_d = step_c;
          count_d = count_q - CW'(1);
        end else if (over_q) begin
          // An over-range shift moves the whole operand out, so the true carry is zero.
          carry_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Handshake and flag outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    y         = y_q;
    carry     = carry_q;
    zero      = (y_q == '0);
  end

endmodule

// File: tb/tb_serial_left_shifter.sv
// Scoreboard bench for serial_left_shifter (N=4), directed vectors.
module tb_serial_left_shifter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] shift;
  logic         rotate;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;
  logic         carry;
  logic         zero;

  serial_left_shifter #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shift     (shift),
`ifdef SERIAL_LEFT_SHIFTER_ROTATE_EN
    .rotate    (rotate),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] y;
    logic         c;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: measures latency to first out_valid, checks on each result handshake.
  exp_t mon_e;
  int   first_cyc = 0;
  logic seen = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen      = 1'b1;
        first_cyc = cyc;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("y", int'(y), int'(mon_e.y));
          chk("carry", int'(carry), int'(mon_e.c));
          chk("zero", int'(zero), int'(mon_e.y == '0));
          chk("latency", first_cyc - mon_e.acc, mon_e.lat);
        end
        seen = 1'b0;
      end
    end
  end

  task automatic send(input logic [N-1:0] av, input logic [N-1:0] sv, input logic rv,
                      input logic [N-1:0] ey, input logic ec, input int el);
    exp_t e;
    int   k;
    @(posedge clk); #2;
    in_valid = 1'b1;
    a        = av;
    shift    = sv;
    rotate   = rv;
    k        = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      e.y   = ey;
      e.c   = ec;
      e.lat = el;
      e.acc = cyc;
      sb.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !in_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] av;
    logic [N-1:0] ey;
    int k;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    shift     = '0;
    rotate    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", int'(y), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #2 reset = 1'b0;

    // Reset in the middle of a shift
    send(4'b1111, 4'd3, 1'b0, 4'b1000, 1'b1, 4);
    @(posedge clk); #3;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_y", int'(y), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_zero", int'(zero), 1);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk); #3 reset = 1'b0;
    send(4'b0001, 4'd1, 1'b0, 4'b0010, 1'b0, 2);
    drain();

    // Basic shift, single-cycle valid pulse
    send(4'b1001, 4'd1, 1'b0, 4'b0010, 1'b1, 2);
    drain();
    chk("valid_pulse_low", int'(out_valid), 0);

    // Sweep with shift=2, hand vector, zero shift
    for (int i = 0; i < 16; i++) begin
      av = 4'(i);
      ey = av << 2;
      send(av, 4'd2, 1'b0, ey, av[2], 3);
    end
    send(4'b1101, 4'd2, 1'b0, 4'b0100, 1'b1, 3);
    send(4'b1011, 4'd0, 1'b0, 4'b1011, 1'b0, 1);
    drain();

    // Range boundaries
    send(4'b0001, 4'd4, 1'b0, 4'b0000, 1'b1, 5);
    send(4'b1111, 4'd9, 1'b0, 4'b0000, 1'b0, 5);
    drain();

    // Back-pressure with a pending request held on the input
    @(posedge clk); #2 out_ready = 1'b0;
    send(4'b0011, 4'd1, 1'b0, 4'b0110, 1'b0, 2);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid_seen", int'(out_valid), 1);
    @(posedge clk); #2;
    in_valid = 1'b1;
    a        = 4'b0101;
    shift    = 4'd1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_y", int'(y), 6);
      chk("bp_carry", int'(carry), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_edge", int'(in_ready), 1);
    @(posedge clk); #1;
    begin
      exp_t e;
      e.y   = 4'b1010;
      e.c   = 1'b0;
      e.lat = 2;
      e.acc = cyc;
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", int'(in_ready), 0);
    drain();

`ifdef SERIAL_LEFT_SHIFTER_ROTATE_EN
    send(4'b1001, 4'd1, 1'b1, 4'b0011, 1'b1, 2);
    send(4'b1001, 4'd5, 1'b1, 4'b0011, 1'b1, 2);
    send(4'b1001, 4'd4, 1'b1, 4'b1001, 1'b0, 1);
    drain();
    rotate = 1'b0;
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_left_shifter.md
Name: serial_left_shifter

Overview:
- Multi-cycle logical left shifter for the ALU datapath; the left-direction counterpart of the combinational logical right shifter.
- Shifts a registered operand one bit per clock under a valid/ready handshake on both input and output sides.
- Lets the ALU sequencer trade latency for area on wide operands.
- Also produces carry-out (last bit shifted out) and zero flags for the ALU flag register.

Parameters:
- N, 4, operand/result width in bits; must be a power of two and at least 2.
- CW, $clog2(N)+1, width of the internal cycle counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- a  input  N  operand.
- shift  input  N  shift amount, unsigned.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- y  output  N  shifted result, registered.
- carry  output  1  last bit shifted out of the MSB.
- zero  output  1  high when y == 0.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state = IDLE, y = 0, carry = 0, count = 0.
  - out_valid = 0, in_ready = 1.
  - zero = 1, since it is combinational from y.
  - Any in-flight operation is discarded.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at a clock edge: y <= a, carry <= 0, count <= s_eff, go to SHIFT.
- Effective shift amount, logical mode:
  - s_eff = min(shift, N).
  - A flag `over` is latched when shift > N.
- SHIFT, per edge:
  - If count != 0: carry <= y[N-1], y <= {y[N-2:0], 1'b0}, count <= count-1.
  - If count == 0: go to DONE. If `over` is set, force carry <= 0, because the true carry of an over-range shift is zero.
- DONE:
  - out_valid = 1; y, carry and zero are held stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored in DONE. There is no back-to-back accept, so in_ready is high at the earliest on the edge after the result handshake.
- Latency: out_valid rises s_eff+1 edges after the accepting edge.
  - shift=0 gives 1 cycle, with y = a and carry = 0.
- Boundaries:
  - shift = N: y = 0, carry = a[0].
  - shift > N: y = 0, carry = 0, latency N+1.
  - out_ready held low: results are held indefinitely.
  - in_valid with X operands while not ready: no effect.
- No arithmetic beyond the decrement. count never underflows; it saturates at 0.

Optional Feature:
- Macro: SERIAL_LEFT_SHIFTER_ROTATE_EN.
- Defined:
  - Adds input port `rotate` (1 bit), sampled at accept.
  - When rotate = 1: s_eff = shift mod N, each step does y <= {y[N-2:0], y[N-1]}, carry <= y[N-1], and `over` is never set.
  - Rotate with shift = N+1 gives a 1-bit rotate.
- Undefined:
  - No `rotate` port; logical behaviour only.

Decomposition:
- Package `shifter_pkg` holds:
  - the state enum typedef (IDLE, SHIFT, DONE);
  - a function clamp_shift(shift, N) returning s_eff and `over`.
- One sub-module: `left_shift_step`.
  - Combinational one-bit stage taking y and rotate, and returning the next y and the carry bit.
  - The FSM instantiates it once.

Test Plan (N=4):
1. After reset:
   - Stimulus: reset pulse mid-SHIFT with a=1111, shift=3.
   - Response: immediately y=0000, out_valid=0, zero=1. The next request a=0001, shift=1 returns y=0010.
2. Basic shift:
   - Stimulus: a=1001, shift=1, out_ready=1.
   - Response: y=0010, carry=1, out_valid 2 edges after accept, pulse 1 cycle.
3. Sweep and zero shift:
   - Stimulus: shift=2 over all 16 values of a.
   - Response: y = (a<<2)&4'hF and carry = a[2]; e.g. a=1101 gives y=0100, carry=1. shift=0 with a=1011 gives y=1011, carry=0, latency 1.
4. Range boundaries:
   - Stimulus: a=0001, shift=4; then a=1111, shift=9.
   - Response: first gives y=0000, carry=1, zero=1. Second gives y=0000, carry=0, latency 5.
5. Back-pressure:
   - Stimulus: out_ready=0 for 10 cycles after out_valid; in_valid held high with a different operand.
   - Response: y, carry and out_valid stay stable; in_ready=0 throughout. After out_ready, IDLE for exactly one edge, then the new request is accepted.
6. Rotate (macro defined):
   - Stimulus: rotate=1, a=1001, shift=1.
   - Response: y=0011, carry=1.
   - Also: a=1001, shift=5 gives y=0011; shift=4 gives y=1001, carry=0.
